// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory data-port arbiter.
//   state_t          : arbiter FSM states
//   PORT_CPU/PORT_DMA: requester indices (0 = CPU load/store, 1 = DMA/IO)
//   ADDR_W_DEF/DATA_W_DEF: default bus widths
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration, see
// mem_arb_pick).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the requester-side and memory-side signals of mem_port_arbiter.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
// them stable until ackN is seen (one-cycle pulse); the request is latched on
// the accepting edge, so later changes do not affect the transfer in flight.
//   slave  : arbiter view (requests and mem_din in; acks, rdata, memory
//            controls out)
//   master : requester/memory environment view (the reverse)
// Optional feature macro: none (MEM_ARB_RR_EN only affects mem_arb_pick).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_dout_en;
    logic [DATA_W-1:0] mem_din;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_din,
        output ack0, ack1, rdata, mem_addr, mem_read, mem_write, mem_dout,
               mem_dout_en
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_din,
        input  ack0, ack1, rdata, mem_addr, mem_read, mem_write, mem_dout,
               mem_dout_en
    );
endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner select between the two requesters.
//   i_req0, i_req1 : live request lines
//   i_last         : index of the port granted most recently
//   o_gnt_valid    : at least one request present
//   o_gnt_idx      : winning port index
// Optional feature macro MEM_ARB_RR_EN:
//   undefined -> fixed priority, port 0 always wins (port 1 may starve)
//   defined   -> round-robin on contention (port not granted last wins);
//                an uncontested request wins regardless of i_last
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_gnt_valid,
    output logic o_gnt_idx
);

    always_comb begin
        o_gnt_valid = i_req0 | i_req1;
        o_gnt_idx   = PORT_CPU;
`ifdef MEM_ARB_RR_EN
        if (i_req0 && i_req1) begin
            o_gnt_idx = ~i_last;
        end else if (i_req1) begin
            o_gnt_idx = PORT_DMA;
        end
`else
        if (!i_req0 && i_req1) begin
            o_gnt_idx = PORT_DMA;
        end
`endif
    end

`ifndef MEM_ARB_RR_EN
    // Fixed priority ignores the grant history.
    logic w_unused_last;
    assign w_unused_last = i_last;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the data port of the 256x16 synchronous memory between the CPU
// load/store unit (port 0) and the DMA/IO engine (port 1). Reads take an
// address cycle then a bus-enable cycle (memory read is registered); writes
// take a single cycle. Completion is a registered one-cycle ack pulse.
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : mem_port_arbiter_if.slave (requests, acks, rdata, memory
//                 address/controls/data)
//   o_dbg_state : current FSM state
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed
// priority; implemented in mem_arb_pick).
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_port_arbiter_if.slave      bus,
    output state_t                 o_dbg_state
);

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack0;
    logic                r_ack1;

    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_accept;

    mem_arb_pick u_pick (
        .i_req0      (bus.req0),
        .i_req1      (bus.req1),
        .i_last      (r_last),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    // Request fields of the winning port.
    assign w_sel_we    = w_gnt_idx ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_gnt_idx ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_gnt_idx ? bus.wdata1 : bus.wdata0;

    // Requests are only sampled in IDLE; DONE never looks at req.
    assign w_accept = (r_state == IDLE) && w_gnt_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_next = w_sel_we ? WR : RD_ADDR;
                end
            end
            RD_ADDR: w_next = RD_DATA;
            RD_DATA: w_next = DONE;
            WR:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= PORT_CPU;
            r_last  <= PORT_DMA;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner <= w_gnt_idx;
                r_last  <= w_gnt_idx;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            // Memory drives d_bus during RD_DATA with the word registered
            // at the end of RD_ADDR.
            if (r_state == RD_DATA) begin
                r_rdata <= bus.mem_din;
            end
            // Ack is registered so it lines up exactly with the DONE state.
            r_ack0 <= (w_next == DONE) && (r_owner == PORT_CPU);
            r_ack1 <= (w_next == DONE) && (r_owner == PORT_DMA);
        end
    end

    // Memory controls decode straight from the state register, so an
    // asynchronous reset drops them without waiting for a clock edge.
    assign bus.mem_addr    = r_addr;
    assign bus.mem_dout    = r_wdata;
    assign bus.mem_read    = (r_state == RD_DATA);
    assign bus.mem_write   = (r_state == WR);
    assign bus.mem_dout_en = (r_state == WR);
    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.rdata       = r_rdata;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
    state_t dbg_state;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- memory model (256x16, registered read) ----------------
    logic [15:0] mem [256];
    logic [15:0] mem_q;
    logic [15:0] shadow [256];

    function automatic logic [15:0] init_val(int i);
        if (i == 'h17) return 16'hFF63;
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_q <= '0;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_dout;
            mem_q <= mem[bus.mem_addr[7:0]];
        end
    end

    assign bus.mem_din = bus.mem_read ? mem_q : (bus.mem_dout_en ? bus.mem_dout : 16'h0000);

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q [$];   // {port, we, data}
    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Invariants, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_rd_wr_excl", {31'b0, !(bus.mem_read && bus.mem_write)}, 32'd1);
            check("inv_douten_eq_wr", {31'b0, bus.mem_dout_en == bus.mem_write}, 32'd1);
            check("inv_one_ack", {31'b0, !(bus.ack0 && bus.ack1)}, 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (port == PORT_CPU) begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic do_req(input logic port, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata);
        logic [15:0] exp_data;
        logic [17:0] e;
        int n;
        int lat;
        int rd_cnt;
        int wr_cnt;
        bit got;
        exp_data = we ? wdata : shadow[addr[7:0]];
        if (we) shadow[addr[7:0]] = wdata;
        exp_q.push_back({port, we, exp_data});
        @(negedge clk);
        drive_port(port, 1'b1, we, addr, wdata);
        got = 0; lat = 0; rd_cnt = 0; wr_cnt = 0; n = 0;
        while (!got && n < 12) begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_read) begin
                rd_cnt++;
                check("rd_phase", n, 32'd2);
                check("rd_addr", {16'b0, bus.mem_addr}, {16'b0, addr});
            end
            if (bus.mem_write) begin
                wr_cnt++;
                check("wr_phase", n, 32'd1);
                check("wr_addr", {16'b0, bus.mem_addr}, {16'b0, addr});
                check("wr_data", {16'b0, bus.mem_dout}, {16'b0, wdata});
            end
            if (bus.ack0 || bus.ack1) begin
                got = 1;
                lat = n;
            end
        end
        drive_port(port, 1'b0, 1'b0, 16'h0000, 16'h0000);
        e = exp_q.pop_front();
        if (!got) begin
            check("ack_timeout", 32'd0, 32'd1);
            return;
        end
        check("ack_port", {30'b0, bus.ack1, bus.ack0}, e[17] ? 32'd2 : 32'd1);
        check("latency", lat, e[16] ? 32'd2 : 32'd3);
        if (!e[16]) check("rdata", {16'b0, bus.rdata}, {16'b0, e[15:0]});
        check("rd_cycles", rd_cnt, e[16] ? 32'd0 : 32'd1);
        check("wr_cycles", wr_cnt, e[16] ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        check("no_dup_ack", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        check("idle_after_done", dbg_state, IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] caddr [2];
        logic        model_last;
        logic        win;
        logic [17:0] e;
        bit          got;
        int          n;

        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        do_reset();

        // Reset state
        #1;
        check("rst_state", dbg_state, IDLE);
        check("rst_acks", {30'b0, bus.ack1, bus.ack0}, 32'd0);
        check("rst_rd_wr_en", {29'b0, bus.mem_read, bus.mem_write, bus.mem_dout_en}, 32'd0);
        check("rst_addr", {16'b0, bus.mem_addr}, 32'd0);
        check("rst_dout", {16'b0, bus.mem_dout}, 32'd0);
        check("rst_rdata", {16'b0, bus.rdata}, 32'd0);

        // Single read, single write + readback
        do_req(PORT_CPU, 1'b0, 16'h0017, 16'h0000);
        do_req(PORT_DMA, 1'b1, 16'h0040, 16'hBEEF);
        do_req(PORT_DMA, 1'b0, 16'h0040, 16'h0000);

        // Back-to-back on port 0, including an aliased upper address
        do_req(PORT_CPU, 1'b0, 16'h1040, 16'h0000);
        do_req(PORT_CPU, 1'b1, 16'h00FF, 16'h0A0A);
        do_req(PORT_CPU, 1'b0, 16'hA5FF, 16'h0000);

        // Random single transfers
        for (int k = 0; k < 6; k++) begin
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end

        // Asynchronous reset during a write
        @(negedge clk);
        drive_port(PORT_DMA, 1'b1, 1'b1, 16'h0055, 16'h1234);
        @(posedge clk); #1;
        check("abort_in_wr", dbg_state, WR);
        check("abort_wr_high", {31'b0, bus.mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_low", {31'b0, bus.mem_write}, 32'd0);
        check("abort_douten_low", {31'b0, bus.mem_dout_en}, 32'd0);
        check("abort_state", dbg_state, IDLE);
        drive_port(PORT_DMA, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_ack", {30'b0, bus.ack1, bus.ack0}, 32'd0);
            check("abort_idle", dbg_state, IDLE);
        end
        do_req(PORT_CPU, 1'b0, 16'h0017, 16'h0000);

        // Contention: both ports hold read requests
        do_reset();
        model_last = PORT_DMA;
        caddr[0] = 16'h0021;
        caddr[1] = 16'h0133;
        @(negedge clk);
        drive_port(PORT_CPU, 1'b1, 1'b0, caddr[0], 16'h0000);
        drive_port(PORT_DMA, 1'b1, 1'b0, caddr[1], 16'h0000);
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            win = ~model_last;
`else
            win = PORT_CPU;
`endif
            model_last = win;
            exp_q.push_back({win, 1'b0, shadow[caddr[win][7:0]]});
            got = 0; n = 0;
            while (!got && n < 12) begin
                @(posedge clk); #1;
                n++;
                if (bus.ack0 || bus.ack1) got = 1;
            end
            e = exp_q.pop_front();
            if (!got) begin
                check("cont_timeout", 32'd0, 32'd1);
                break;
            end
            check("cont_port", {30'b0, bus.ack1, bus.ack0}, e[17] ? 32'd2 : 32'd1);
            check("cont_rdata", {16'b0, bus.rdata}, {16'b0, e[15:0]});
        end
        @(negedge clk);
        drive_port(PORT_CPU, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_port(PORT_DMA, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (6) @(posedge clk);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
